decode_job_ctrl: RTL and testbench
==================================

Name: decode_job_ctrl

Overview:
- Scheduler/sequencer for one decode_rp core. Queues decode jobs, each with input-buffer base, output-buffer base and tag.
- Launches jobs back-to-back with the core's start/done handshake and relocates the core's rp read and cd write addresses into shared memories.
- Reports completion or timeout per job. Sits between the host/top-level job issuer and the decoder core plus its BRAMs.

Parameters:
- IN_AW, 10, width of relocated rp read address (core address width is also IN_AW).
- OUT_AW, 10, width of relocated cd write address (core address width is also OUT_AW).
- D_W, 13, cd write data width (RP_D_SIZE).
- ID_W, 4, job tag width.
- QDEPTH, 4, job queue depth (power of 2, >=2).
- START_CYC, 6, cycles core_start is held high per launch (>=1).
- TO_W, 16, timeout counter width; timeout fires after 2^TO_W-1 RUN cycles.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- job_valid  in  1  job offered.
- job_ready  out  1  queue not full; a job is accepted when job_valid&&job_ready.
- job_in_base  in  IN_AW  input buffer base.
- job_out_base  in  OUT_AW  output buffer base.
- job_id  in  ID_W  job tag.
- core_start  out  1  start to decode_rp.
- core_done  in  1  decode_rp done (level; stays high after finishing).
- core_rp_rd_addr  in  IN_AW  core read address.
- mem_rd_addr  out  IN_AW  core_rp_rd_addr+in_base, mod 2^IN_AW, combinational.
- core_cd_wr_addr  in  OUT_AW  core write address.
- core_cd_wr_data  in  D_W  core write data.
- core_cd_wr_en  in  1  core write enable.
- mem_wr_addr  out  OUT_AW  core_cd_wr_addr+out_base, mod 2^OUT_AW, combinational.
- mem_wr_data  out  D_W  core_cd_wr_data, pass-through.
- mem_wr_en  out  1  core_cd_wr_en gated by state RUN.
- cmp_valid  out  1  one-cycle completion pulse.
- cmp_id  out  ID_W  tag of completed job; held until next completion.
- cmp_timeout  out  1  completion was a timeout; held with cmp_id.
- busy  out  1  state != IDLE or queue non-empty.
- abort  in  1  synchronous kill of the current job.

Behaviour:
- Reset, asynchronous: state IDLE, queue empty, core_start=0, cmp_valid=0, cmp_id=0, cmp_timeout=0, in_base/out_base regs=0, timeout counter=0, armed=0. job_ready=1 after reset.
- Queue: FIFO of {in_base,out_base,id}.
  - Push on job_valid&&job_ready.
  - Pop only on the IDLE->LAUNCH transition.
  - Simultaneous push and pop on a full queue is not allowed: job_ready is derived from the count before the pop.
- States:
  - IDLE: if queue non-empty, pop the head into in_base/out_base/cur_id and go to LAUNCH. Otherwise stay.
  - LAUNCH: core_start=1 for exactly START_CYC cycles (counter), then go to RUN. Clear armed and timeout counter on entry.
  - RUN:
    - armed is set the first cycle core_done==0.
    - Completion occurs when armed&&core_done; a stale high done from the previous job is ignored until it has been seen low.
    - On completion: cmp_valid=1 next cycle, cmp_id=cur_id, cmp_timeout=0, go to IDLE.
    - Timeout counter increments each RUN cycle. At all-ones: complete with cmp_timeout=1 and go to IDLE.
  - abort in LAUNCH or RUN: drop core_start, complete with cmp_timeout=1 and go to IDLE next cycle. abort in IDLE is ignored. abort has priority over a simultaneous done.
- Back-to-back: the earliest relaunch is the cycle after completion (IDLE is held for 1 cycle), giving a minimum of START_CYC+3 cycles between start rising edges.
- mem_wr_en=0 outside RUN, which blocks writes in LAUNCH, IDLE and after an abort. mem_rd_addr is always relocated by the current in_base.
- Address arithmetic wraps modulo 2^width with no overflow flag.
- busy=0 only when IDLE and the queue is empty.

Test Plan:
- Single job: in_base=0x100, out_base=0x040, id=3, core done after 200 cycles -> core_start high 6 cycles; core_rd_addr 5 -> mem_rd_addr 0x105; core_wr_addr 2 with wr_en -> mem_wr_addr 0x042 with mem_wr_en=1; cmp_valid pulse with id=3, timeout=0; busy falls.
- Stale done: core_done held high from the previous job through LAUNCH and for 3 RUN cycles, then low 10 cycles, then high -> no completion until the second rising of done; exactly one cmp_valid.
- Queue full: push 4 jobs (ids 1..4) while the first runs -> job_ready=0 after the 4th; a 5th job_valid is not accepted. Completions appear in order 1,2,3,4 with start rising edges at least 9 cycles apart.
- Timeout with TO_W=4: core_done never asserted -> cmp_valid with cmp_timeout=1 after 15 RUN cycles; the next queued job launches.
- Abort: abort during RUN with wr_en active -> mem_wr_en low from the next cycle; cmp_timeout=1. Abort in the same cycle as done -> a single completion with timeout=1.
- Reset mid-RUN: rst_n low asynchronously -> core_start=0, cmp_valid=0, queue empty, job_ready=1 immediately; no completion pulse after release.

Source files
------------

// File: rtl/decode_job_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : decode_job_ctrl
// Purpose  : Job scheduler for one decode_rp core. Queues jobs of
//            {in_base, out_base, id}, launches them one at a time with a
//            held start pulse, waits for a fresh done (or a timeout or an
//            abort), and reports a one-cycle completion carrying the tag.
//            While a job runs, the core's rp read address and cd write
//            address are relocated into the shared memories.
// Ports    : clk, rst_n           - clock, async active-low reset
//            job_*                - job offer (valid/ready) with bases and tag
//            core_start/core_done - core handshake (done is a level)
//            core_rp_rd_addr      -> mem_rd_addr (relocated by in_base)
//            core_cd_wr_*         -> mem_wr_* (relocated by out_base, gated)
//            cmp_valid/id/timeout - completion report
//            busy                 - any job queued or in flight
//            abort                - kill the current job
// Revision : 1.0 - initial release
// ============================================================================
module decode_job_ctrl #(
   parameter int IN_AW     = 10,
   parameter int OUT_AW    = 10,
   parameter int D_W       = 13,
   parameter int ID_W      = 4,
   parameter int QDEPTH    = 4,
   parameter int START_CYC = 6,
   parameter int TO_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              job_valid,
   output logic              job_ready,
   input  logic [IN_AW-1:0]  job_in_base,
   input  logic [OUT_AW-1:0] job_out_base,
   input  logic [ID_W-1:0]   job_id,
   output logic              core_start,
   input  logic              core_done,
   input  logic [IN_AW-1:0]  core_rp_rd_addr,
   output logic [IN_AW-1:0]  mem_rd_addr,
   input  logic [OUT_AW-1:0] core_cd_wr_addr,
   input  logic [D_W-1:0]    core_cd_wr_data,
   input  logic              core_cd_wr_en,
   output logic [OUT_AW-1:0] mem_wr_addr,
   output logic [D_W-1:0]    mem_wr_data,
   output logic              mem_wr_en,
   output logic              cmp_valid,
   output logic [ID_W-1:0]   cmp_id,
   output logic              cmp_timeout,
   output logic              busy,
   input  logic              abort
);

   localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int SC_W  = (START_CYC > 1) ? $clog2(START_CYC) : 1;
   localparam int E_W   = IN_AW + OUT_AW + ID_W;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_RUN    = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [E_W-1:0]    fifo_q [QDEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic [IN_AW-1:0]  in_base_q, in_base_d;
   logic [OUT_AW-1:0] out_base_q, out_base_d;
   logic [ID_W-1:0]   cur_id_q, cur_id_d;
   logic [SC_W-1:0]   sc_q, sc_d;
   logic [TO_W-1:0]   to_q, to_d;
   logic              armed_q, armed_d;
   logic              cmp_valid_q, cmp_valid_d;
   logic [ID_W-1:0]   cmp_id_q, cmp_id_d;
   logic              cmp_to_q, cmp_to_d;
   logic              push, pop, q_empty, q_full;

   assign q_empty   = (count_q == '0);
   // Full is judged on the count before any pop this cycle.
   assign q_full    = (count_q == CNT_W'(QDEPTH));
   assign job_ready = !q_full;
   assign push      = job_valid && !q_full;

   // Queue storage carries no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[wr_ptr_q] <= {job_in_base, job_out_base, job_id};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         in_base_q   <= '0;
         out_base_q  <= '0;
         cur_id_q    <= '0;
         sc_q        <= '0;
         to_q        <= '0;
         armed_q     <= 1'b0;
         cmp_valid_q <= 1'b0;
         cmp_id_q    <= '0;
         cmp_to_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_base_q   <= in_base_d;
         out_base_q  <= out_base_d;
         cur_id_q    <= cur_id_d;
         sc_q        <= sc_d;
         to_q        <= to_d;
         armed_q     <= armed_d;
         cmp_valid_q <= cmp_valid_d;
         cmp_id_q    <= cmp_id_d;
         cmp_to_q    <= cmp_to_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      in_base_d   = in_base_q;
      out_base_d  = out_base_q;
      cur_id_d    = cur_id_q;
      sc_d        = sc_q;
      to_d        = to_q;
      armed_d     = armed_q;
      cmp_valid_d = 1'b0;
      cmp_id_d    = cmp_id_q;
      cmp_to_d    = cmp_to_q;
      pop         = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!q_empty) begin
               pop = 1'b1;
               {in_base_d, out_base_d, cur_id_d} = fifo_q[rd_ptr_q];
               sc_d    = '0;
               to_d    = '0;
               armed_d = 1'b0;
               state_d = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            if (abort) begin
               cmp_valid_d = 1'b1;
               cmp_id_d    = cur_id_q;
               cmp_to_d    = 1'b1;
               state_d     = S_IDLE;
            end else if (sc_q == SC_W'(START_CYC - 1)) begin
               state_d = S_RUN;
            end else begin
               sc_d = sc_q + SC_W'(1);
            end
         end
         S_RUN: begin
            to_d = to_q + TO_W'(1);
            // done must be seen low once, so a level left high by the
            // previous job cannot complete this one.
            if (!core_done) armed_d = 1'b1;
            if (abort || (armed_q && core_done) || (&to_q)) begin
               cmp_valid_d = 1'b1;
               cmp_id_d    = cur_id_q;
               // abort outranks a simultaneous done
               cmp_to_d    = abort || !(armed_q && core_done);
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign core_start  = (state_q == S_LAUNCH);
   assign mem_rd_addr = core_rp_rd_addr + in_base_q;
   assign mem_wr_addr = core_cd_wr_addr + out_base_q;
   assign mem_wr_data = core_cd_wr_data;
   assign mem_wr_en   = core_cd_wr_en && (state_q == S_RUN);
   assign cmp_valid   = cmp_valid_q;
   assign cmp_id      = cmp_id_q;
   assign cmp_timeout = cmp_to_q;
   assign busy        = (state_q != S_IDLE) || !q_empty;

endmodule
`default_nettype wire

// File: tb/tb_decode_job_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_job_ctrl
// Purpose  : Directed self-checking bench for decode_job_ctrl. A default
//            instance covers launch, relocation, stale done, queueing,
//            abort and reset; a TO_W=4 instance covers the timeout.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_job_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        job_valid, job_valid_t;
   logic [9:0]  job_in_base, job_out_base;
   logic [3:0]  job_id;
   logic        core_done, core_done_t;
   logic [9:0]  core_rp_rd_addr, core_cd_wr_addr;
   logic [12:0] core_cd_wr_data;
   logic        core_cd_wr_en;
   logic        abort, abort_t;

   logic        job_ready, core_start, mem_wr_en, cmp_valid, cmp_timeout, busy;
   logic [9:0]  mem_rd_addr, mem_wr_addr;
   logic [12:0] mem_wr_data;
   logic [3:0]  cmp_id;

   logic        job_ready_t, core_start_t, mem_wr_en_t, cmp_valid_t, cmp_timeout_t, busy_t;
   logic [9:0]  mem_rd_addr_t, mem_wr_addr_t;
   logic [12:0] mem_wr_data_t;
   logic [3:0]  cmp_id_t;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   decode_job_ctrl u_dut (
      .clk(clk), .rst_n(rst_n),
      .job_valid(job_valid), .job_ready(job_ready),
      .job_in_base(job_in_base), .job_out_base(job_out_base), .job_id(job_id),
      .core_start(core_start), .core_done(core_done),
      .core_rp_rd_addr(core_rp_rd_addr), .mem_rd_addr(mem_rd_addr),
      .core_cd_wr_addr(core_cd_wr_addr), .core_cd_wr_data(core_cd_wr_data),
      .core_cd_wr_en(core_cd_wr_en),
      .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en),
      .cmp_valid(cmp_valid), .cmp_id(cmp_id), .cmp_timeout(cmp_timeout),
      .busy(busy), .abort(abort)
   );

   decode_job_ctrl #(.TO_W(4)) u_dut_to (
      .clk(clk), .rst_n(rst_n),
      .job_valid(job_valid_t), .job_ready(job_ready_t),
      .job_in_base(job_in_base), .job_out_base(job_out_base), .job_id(job_id),
      .core_start(core_start_t), .core_done(core_done_t),
      .core_rp_rd_addr(core_rp_rd_addr), .mem_rd_addr(mem_rd_addr_t),
      .core_cd_wr_addr(core_cd_wr_addr), .core_cd_wr_data(core_cd_wr_data),
      .core_cd_wr_en(core_cd_wr_en),
      .mem_wr_addr(mem_wr_addr_t), .mem_wr_data(mem_wr_data_t), .mem_wr_en(mem_wr_en_t),
      .cmp_valid(cmp_valid_t), .cmp_id(cmp_id_t), .cmp_timeout(cmp_timeout_t),
      .busy(busy_t), .abort(abort_t)
   );

   // All tasks start and end just after a falling edge.
   task automatic push(input logic [9:0] ib, input logic [9:0] ob, input logic [3:0] id);
      job_valid = 1'b1; job_in_base = ib; job_out_base = ob; job_id = id;
      @(negedge clk);
      job_valid = 1'b0;
   endtask

   task automatic push_t(input logic [9:0] ib, input logic [9:0] ob, input logic [3:0] id);
      job_valid_t = 1'b1; job_in_base = ib; job_out_base = ob; job_id = id;
      @(negedge clk);
      job_valid_t = 1'b0;
   endtask

   // Waits until the selected instance's core_start equals lvl.
   task automatic wait_start(input bit sel_to, input logic lvl, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if ((sel_to ? core_start_t : core_start) === lvl) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      core_cd_wr_en = 1'b1; core_rp_rd_addr = 10'h07;
      #1;
      n_cmp++; if (job_ready !== 1'b1)  begin n_fail++; $display("FAIL rst_ready: got %b want 1", job_ready); end
      n_cmp++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_cmp++; if (core_start !== 1'b0) begin n_fail++; $display("FAIL rst_start: got %b want 0", core_start); end
      n_cmp++; if ({cmp_valid, cmp_timeout, cmp_id} !== 6'd0)
                  begin n_fail++; $display("FAIL rst_cmp: got %b/%b/%h want 0/0/0", cmp_valid, cmp_timeout, cmp_id); end
      n_cmp++; if (mem_wr_en !== 1'b0)  begin n_fail++; $display("FAIL rst_wr_en: got %b want 0", mem_wr_en); end
      n_cmp++; if (mem_rd_addr !== 10'h07) begin n_fail++; $display("FAIL rst_rd_addr: got %h want 007", mem_rd_addr); end
      n_cmp++; if (job_ready_t !== 1'b1) begin n_fail++; $display("FAIL rst_ready_to: got %b want 1", job_ready_t); end
      core_cd_wr_en = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single_job();
      bit ok; int hc;
      push(10'h100, 10'h040, 4'd3);
      core_cd_wr_en = 1'b1;
      wait_start(1'b0, 1'b1, 10, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL single_start_rise: got no start want start"); end
      n_cmp++; if (mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL single_wr_en_launch: got %b want 0", mem_wr_en); end
      hc = 0;
      while (core_start && hc < 20) begin hc++; @(negedge clk); end
      n_cmp++; if (hc != 6) begin n_fail++; $display("FAIL single_start_len: got %0d want 6", hc); end
      core_rp_rd_addr = 10'd5; core_cd_wr_addr = 10'd2; core_cd_wr_data = 13'h1234;
      #1;
      n_cmp++; if (mem_rd_addr !== 10'h105) begin n_fail++; $display("FAIL single_rd_addr: got %h want 105", mem_rd_addr); end
      n_cmp++; if (mem_wr_addr !== 10'h042) begin n_fail++; $display("FAIL single_wr_addr: got %h want 042", mem_wr_addr); end
      n_cmp++; if (mem_wr_en !== 1'b1) begin n_fail++; $display("FAIL single_wr_en_run: got %b want 1", mem_wr_en); end
      n_cmp++; if (mem_wr_data !== 13'h1234) begin n_fail++; $display("FAIL single_wr_data: got %h want 1234", mem_wr_data); end
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_run: got %b want 1", busy); end
      core_cd_wr_en = 1'b0;
      repeat (200) @(negedge clk);
      n_cmp++; if (cmp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_cmp: got %b want 0", cmp_valid); end
      core_done = 1'b1;
      hc = 0;
      while (!cmp_valid && hc < 10) begin hc++; @(negedge clk); end
      n_cmp++; if (cmp_valid !== 1'b1) begin n_fail++; $display("FAIL single_cmp: got %b want 1", cmp_valid); end
      n_cmp++; if ({cmp_id, cmp_timeout} !== {4'd3, 1'b0})
                  begin n_fail++; $display("FAIL single_cmp_fields: got id %h to %b want id 3 to 0", cmp_id, cmp_timeout); end
      @(negedge clk);
      n_cmp++; if (cmp_valid !== 1'b0) begin n_fail++; $display("FAIL single_pulse_len: got %b want 0", cmp_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b want 0", busy); end
      n_cmp++; if (cmp_id !== 4'd3) begin n_fail++; $display("FAIL single_id_hold: got %h want 3", cmp_id); end
   endtask

   task automatic test_stale_done();
      bit ok; int nc, pre;
      // core_done is still high from the previous job
      push(10'h000, 10'h000, 4'd5);
      wait_start(1'b0, 1'b1, 10, ok);
      wait_start(1'b0, 1'b0, 20, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL stale_run: got no RUN want RUN"); end
      nc = 0;
      for (int i = 0; i < 3; i++) begin if (cmp_valid) nc++; @(negedge clk); end
      core_done = 1'b0;
      for (int i = 0; i < 10; i++) begin if (cmp_valid) nc++; @(negedge clk); end
      pre = nc;
      n_cmp++; if (pre != 0) begin n_fail++; $display("FAIL stale_early: got %0d completions want 0", pre); end
      core_done = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (cmp_valid) begin
            nc++;
            n_cmp++; if ({cmp_id, cmp_timeout} !== {4'd5, 1'b0})
                        begin n_fail++; $display("FAIL stale_fields: got id %h to %b want id 5 to 0", cmp_id, cmp_timeout); end
         end
         @(negedge clk);
      end
      n_cmp++; if (nc != 1) begin n_fail++; $display("FAIL stale_count: got %0d completions want 1", nc); end
   endtask

   task automatic test_queue_full();
      int rise_t[$];
      logic [3:0] ids[$];
      logic prev;
      int dcnt;
      push(10'h000, 10'h000, 4'd0);
      for (int j = 1; j <= 4; j++) push(10'(j * 16), 10'(j * 8), 4'(j));
      n_cmp++; if (job_ready !== 1'b0) begin n_fail++; $display("FAIL qfull_ready: got %b want 0", job_ready); end
      job_valid = 1'b1; job_id = 4'd9;
      @(negedge clk);
      job_valid = 1'b0;
      n_cmp++; if (job_ready !== 1'b0) begin n_fail++; $display("FAIL qfull_ready_hold: got %b want 0", job_ready); end
      prev = core_start; dcnt = 0;
      for (int c = 0; c < 120; c++) begin
         if (core_start && !prev) rise_t.push_back(c);
         prev = core_start;
         if (cmp_valid) ids.push_back(cmp_id);
         // core model: drop done while started, raise it 3 cycles after start falls
         if (core_start) begin core_done = 1'b0; dcnt = 0; end
         else if (!core_done) begin dcnt++; if (dcnt == 3) core_done = 1'b1; end
         @(negedge clk);
      end
      n_cmp++; if (ids.size() != 5) begin n_fail++; $display("FAIL qfull_ncmp: got %0d want 5", ids.size()); end
      for (int i = 0; i < ids.size() && i < 5; i++) begin
         n_cmp++; if (ids[i] !== 4'(i)) begin n_fail++; $display("FAIL qfull_order[%0d]: got %h want %h", i, ids[i], i); end
      end
      n_cmp++; if (rise_t.size() != 4) begin n_fail++; $display("FAIL qfull_nrise: got %0d want 4", rise_t.size()); end
      for (int i = 1; i < rise_t.size(); i++) begin
         n_cmp++; if (rise_t[i] - rise_t[i-1] != 10)
                     begin n_fail++; $display("FAIL qfull_spacing[%0d]: got %0d want 10", i, rise_t[i] - rise_t[i-1]); end
      end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL qfull_busy_end: got %b want 0", busy); end
   endtask

   task automatic test_timeout();
      bit ok; int hc, k;
      push_t(10'h000, 10'h000, 4'd7);
      push_t(10'h000, 10'h000, 4'd8);
      wait_start(1'b1, 1'b1, 10, ok);
      hc = 0;
      while (core_start_t && hc < 20) begin hc++; @(negedge clk); end
      n_cmp++; if (hc != 6) begin n_fail++; $display("FAIL to_start_len: got %0d want 6", hc); end
      k = 1;
      while (!cmp_valid_t && k < 40) begin @(negedge clk); k++; end
      n_cmp++; if (k != 17) begin n_fail++; $display("FAIL to_latency: got %0d want 17", k); end
      n_cmp++; if ({cmp_valid_t, cmp_timeout_t, cmp_id_t} !== {1'b1, 1'b1, 4'd7})
                  begin n_fail++; $display("FAIL to_fields: got v %b to %b id %h want 1/1/7", cmp_valid_t, cmp_timeout_t, cmp_id_t); end
      @(negedge clk);
      n_cmp++; if (core_start_t !== 1'b1) begin n_fail++; $display("FAIL to_relaunch: got %b want 1", core_start_t); end
      k = 0;
      while (!cmp_valid_t && k < 40) begin @(negedge clk); k++; end
      n_cmp++; if ({cmp_valid_t, cmp_timeout_t, cmp_id_t} !== {1'b1, 1'b1, 4'd8})
                  begin n_fail++; $display("FAIL to_second: got v %b to %b id %h want 1/1/8", cmp_valid_t, cmp_timeout_t, cmp_id_t); end
      @(negedge clk);
      n_cmp++; if (busy_t !== 1'b0) begin n_fail++; $display("FAIL to_busy_end: got %b want 0", busy_t); end
   endtask

   task automatic test_abort();
      bit ok; int nc;
      push(10'h3FF, 10'h3FE, 4'd6);
      core_done = 1'b0;
      wait_start(1'b0, 1'b1, 10, ok);
      wait_start(1'b0, 1'b0, 20, ok);
      core_rp_rd_addr = 10'd2; core_cd_wr_addr = 10'd3; core_cd_wr_en = 1'b1;
      #1;
      n_cmp++; if (mem_rd_addr !== 10'h001) begin n_fail++; $display("FAIL abort_rd_wrap: got %h want 001", mem_rd_addr); end
      n_cmp++; if (mem_wr_addr !== 10'h001) begin n_fail++; $display("FAIL abort_wr_wrap: got %h want 001", mem_wr_addr); end
      @(negedge clk);
      abort = 1'b1;
      #1;
      n_cmp++; if (mem_wr_en !== 1'b1) begin n_fail++; $display("FAIL abort_wr_en_same: got %b want 1", mem_wr_en); end
      @(negedge clk);
      abort = 1'b0;
      #1;
      n_cmp++; if (mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL abort_wr_en_next: got %b want 0", mem_wr_en); end
      n_cmp++; if ({cmp_valid, cmp_timeout, cmp_id} !== {1'b1, 1'b1, 4'd6})
                  begin n_fail++; $display("FAIL abort_cmp: got v %b to %b id %h want 1/1/6", cmp_valid, cmp_timeout, cmp_id); end
      n_cmp++; if (core_start !== 1'b0) begin n_fail++; $display("FAIL abort_start: got %b want 0", core_start); end
      core_cd_wr_en = 1'b0;
      @(negedge clk);
      // abort and done in the same cycle
      push(10'h000, 10'h000, 4'd10);
      wait_start(1'b0, 1'b1, 10, ok);
      wait_start(1'b0, 1'b0, 20, ok);
      @(negedge clk);
      core_done = 1'b1; abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n_cmp++; if ({cmp_valid, cmp_timeout, cmp_id} !== {1'b1, 1'b1, 4'd10})
                  begin n_fail++; $display("FAIL abort_done_cmp: got v %b to %b id %h want 1/1/a", cmp_valid, cmp_timeout, cmp_id); end
      nc = 0;
      for (int i = 0; i < 10; i++) begin @(negedge clk); if (cmp_valid) nc++; end
      n_cmp++; if (nc != 0) begin n_fail++; $display("FAIL abort_done_extra: got %0d want 0", nc); end
      // abort while idle does nothing
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n_cmp++; if ({cmp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL abort_idle: got v %b busy %b want 0/0", cmp_valid, busy); end
   endtask

   task automatic test_reset_mid_run();
      bit ok; int nc, ns;
      push(10'h000, 10'h000, 4'd11);
      push(10'h000, 10'h000, 4'd12);
      core_done = 1'b0;
      wait_start(1'b0, 1'b1, 10, ok);
      wait_start(1'b0, 1'b0, 20, ok);
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before: got %b want 1", busy); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if ({core_start, cmp_valid} !== 2'b00) begin n_fail++; $display("FAIL rmid_outs: got start %b v %b want 0/0", core_start, cmp_valid); end
      n_cmp++; if ({job_ready, busy} !== 2'b10) begin n_fail++; $display("FAIL rmid_queue: got ready %b busy %b want 1/0", job_ready, busy); end
      @(negedge clk);
      rst_n = 1'b1;
      core_done = 1'b1;
      nc = 0; ns = 0;
      for (int i = 0; i < 20; i++) begin @(negedge clk); if (cmp_valid) nc++; if (core_start) ns++; end
      n_cmp++; if (nc != 0) begin n_fail++; $display("FAIL rmid_cmp_after: got %0d want 0", nc); end
      n_cmp++; if (ns != 0) begin n_fail++; $display("FAIL rmid_start_after: got %0d want 0", ns); end
   endtask

   initial begin
      rst_n = 1'b0;
      job_valid = 1'b0; job_valid_t = 1'b0;
      job_in_base = '0; job_out_base = '0; job_id = '0;
      core_done = 1'b0; core_done_t = 1'b0;
      core_rp_rd_addr = '0; core_cd_wr_addr = '0; core_cd_wr_data = '0; core_cd_wr_en = 1'b0;
      abort = 1'b0; abort_t = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_single_job();
      test_stale_done();
      test_queue_full();
      test_timeout();
      test_abort();
      test_reset_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
